// File: rtl/float_div_16bit_seq.sv
// Sequential half-precision divider (float1 / float2), restoring mantissa loop, RNE rounding.
// Optional status flags port enabled by defining FPU_DIV_STATUS_EN.
package fpu_types_pkg;
    localparam int HALF_FLOAT_W    = 16;
    localparam int HALF_EXPONENT_W = 5;
    localparam int HALF_FRACTION_W = 10;
endpackage

module float_div_16bit_seq
    import fpu_types_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [HALF_FLOAT_W-1:0] float1,
    input  logic [HALF_FLOAT_W-1:0] float2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [HALF_FLOAT_W-1:0] quotient
`ifdef FPU_DIV_STATUS_EN
    ,output logic [4:0]             flags
`endif
);
    localparam int EW = HALF_EXPONENT_W;
    localparam int FW = HALF_FRACTION_W;
    localparam logic [EW-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    state_t              state_q;
    logic                in_ready_q, out_valid_q;
    logic [HALF_FLOAT_W-1:0] quot_q;
    logic [3:0]          cnt_q;
    logic [FW+1:0]       rem_q;
    logic [FW:0]         div_q;
    logic [FW+2:0]       q_q;
    logic signed [6:0]   exp_q;
    logic                sign_q;

    // Operand decode for the accept cycle
    logic [EW-1:0]       e1, e2;
    logic [FW-1:0]       m1, m2;
    logic                s_x, z1, z2, inf1, inf2, nan1, nan2;
    logic                invalid_d, dbz_d, spec_d;
    logic [HALF_FLOAT_W-1:0] spec_quot_d;
    logic signed [6:0]   exp_d;

    always_comb begin
        e1   = float1[HALF_FLOAT_W-2 -: EW];
        e2   = float2[HALF_FLOAT_W-2 -: EW];
        m1   = float1[FW-1:0];
        m2   = float2[FW-1:0];
        s_x  = float1[HALF_FLOAT_W-1] ^ float2[HALF_FLOAT_W-1];
        z1   = (e1 == '0);
        z2   = (e2 == '0);
        inf1 = (e1 == EXP_MAX) && (m1 == '0);
        inf2 = (e2 == EXP_MAX) && (m2 == '0);
        nan1 = (e1 == EXP_MAX) && (m1 != '0);
        nan2 = (e2 == EXP_MAX) && (m2 != '0);
        invalid_d = nan1 | nan2 | (z1 & z2) | (inf1 & inf2);
        dbz_d     = z2 & ~z1 & ~inf1 & ~nan1;
        spec_d    = invalid_d | z1 | z2 | inf1 | inf2;
        if (invalid_d)
            spec_quot_d = '1;
        else if (z2 || inf1)
            spec_quot_d = {s_x, EXP_MAX, {FW{1'b0}}};
        else
            spec_quot_d = {s_x, {(HALF_FLOAT_W-1){1'b0}}};
        exp_d = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 7'sd15;
    end

    // One restoring step per DIV cycle
    logic          ge;
    logic [FW+1:0] rem_sel;

    always_comb begin
        ge      = rem_q >= {1'b0, div_q};
        rem_sel = ge ? (rem_q - {1'b0, div_q}) : rem_q;
    end

    // Normalise, round to nearest even, then range-check the exponent
    logic [FW-1:0]       mant_pre, mant_r;
    logic                guard, sticky, up, ovf, unf;
    logic signed [6:0]   e_adj, e_rnd;
    logic [FW:0]         mant_sum;
    logic [HALF_FLOAT_W-1:0] round_quot_d;

    always_comb begin
        if (q_q[FW+2]) begin
            mant_pre = q_q[FW+1:2];
            guard    = q_q[1];
            sticky   = q_q[0] | (|rem_q);
            e_adj    = exp_q;
        end else begin
            mant_pre = q_q[FW:1];
            guard    = q_q[0];
            sticky   = |rem_q;
            e_adj    = exp_q - 7'sd1;
        end
        up       = guard & (sticky | mant_pre[0]);
        mant_sum = {1'b0, mant_pre} + {{FW{1'b0}}, up};
        if (mant_sum[FW]) begin
            mant_r = '0;
            e_rnd  = e_adj + 7'sd1;
        end else begin
            mant_r = mant_sum[FW-1:0];
            e_rnd  = e_adj;
        end
        ovf = e_rnd >= 7'sd31;
        unf = e_rnd <= 7'sd0;
        if (ovf)
            round_quot_d = {sign_q, EXP_MAX, {FW{1'b0}}};
        else if (unf)
            round_quot_d = {sign_q, {(HALF_FLOAT_W-1){1'b0}}};
        else
            round_quot_d = {sign_q, e_rnd[EW-1:0], mant_r};
    end

`ifdef FPU_DIV_STATUS_EN
    logic [4:0] flags_q;
    logic [4:0] spec_flags_d, round_flags_d;

    always_comb begin
        spec_flags_d  = {invalid_d, dbz_d & ~invalid_d, 3'b000};
        round_flags_d = {2'b00, ovf, unf, guard | sticky | ovf | unf};
    end

    assign flags = flags_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            q_q         <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
`ifdef FPU_DIV_STATUS_EN
            flags_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q     <= s_x;
                        in_ready_q <= 1'b0;
                        if (spec_d) begin
                            quot_q      <= spec_quot_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
`ifdef FPU_DIV_STATUS_EN
                            flags_q     <= spec_flags_d;
`endif
                        end else begin
                            rem_q   <= {2'b01, m1};
                            div_q   <= {1'b1, m2};
                            q_q     <= '0;
                            exp_q   <= exp_d;
                            cnt_q   <= '0;
                            state_q <= DIV;
                        end
                    end
                end
                DIV: begin
                    q_q   <= {q_q[FW+1:0], ge};
                    rem_q <= rem_sel << 1;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd12)
                        state_q <= ROUND;
                end
                ROUND: begin
                    quot_q      <= round_quot_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
`ifdef FPU_DIV_STATUS_EN
                    flags_q     <= round_flags_d;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;
endmodule

// File: doc/float_div_16bit_seq.md
# float_div_16bit_seq

Sequential IEEE-754 half-precision (1/5/10, bias 15) divider computing `float1 / float2` with round-to-nearest-even. It is the inverse operation to the half-precision multiplier in the FPU datapath. It uses an iterative restoring mantissa divider behind valid/ready handshakes on both sides. One operation is in flight at a time.

## Interface
Parameters:
- none. Widths come from `fpu_types_pkg`: `HALF_FLOAT_W`=16, `HALF_EXPONENT_W`=5, `HALF_FRACTION_W`=10.

Ports:
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  reset. One clock; reset is synchronous and active-high.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  divider can accept operands. High only in IDLE.
- `float1`  in  16  dividend.
- `float2`  in  16  divisor.
- `out_valid`  out  1  `quotient` is valid.
- `out_ready`  in  1  consumer accepts the result.
- `quotient`  out  16  result.
- `flags`  out  5  {invalid, div_by_zero, overflow, underflow, inexact}. Present only with `FPU_DIV_STATUS_EN`.

## Operation
- FSM states: IDLE, DIV, ROUND, DONE.
- Operands are captured on `in_valid & in_ready`.
- Subnormal inputs (exp==0) are flushed to zero.
- Special cases go IDLE->DONE directly:
  - Any NaN operand, 0/0, or inf/inf -> 16'hFFFF.
  - Finite nonzero / 0 -> inf, {s1^s2, 5'h1F, 10'h0}.
  - inf / finite -> signed inf.
  - 0 / nonzero-finite or finite / inf -> signed zero {s1^s2, 15'h0}.
- Normal path:
  - A = {1, m1}, B = {1, m2}, each 11 bits.
  - Remainder R is 12 bits, initialised to A.
  - 13 DIV iterations, MSB first: if R >= B then q bit = 1 and R = R - B, else q bit = 0; then R = R << 1.
  - Result q[12:0], with q[12] the integer bit.
- Exponent: E = e1 - e2 + 15, held as signed 7-bit.
- ROUND state:
  - If q[12] = 1: mant = q[11:2], guard = q[1], sticky = q[0] | (R != 0).
  - If q[12] = 0: mant = q[10:1], guard = q[0], sticky = (R != 0), and E = E - 1.
  - Round up when guard & (sticky | mant[0]).
  - Mantissa carry-out sets mant = 0 and E = E + 1.
  - E >= 31 -> signed inf.
  - E <= 0 -> signed zero (no subnormal outputs).
- DONE:
  - `out_valid` = 1; `quotient` and `flags` are held stable.
  - `out_valid & out_ready` -> IDLE.
  - `in_ready` stays low in DONE, so no new operand is accepted in the handshake cycle.
- `in_valid` is ignored whenever `in_ready` = 0.

## Timing
- Reset values: `in_ready`=1 (state IDLE), `out_valid`=0, `quotient`=16'h0000, `flags`=5'b0. Iteration counter = 0.
- Counting the accept edge as edge 0:
  - Normal path: DIV occupies cycles 1-13, ROUND cycle 14, `out_valid` high from cycle 15. Latency is 15.
  - Special path: `out_valid` high from cycle 1.
- `RST` asserted in any state aborts the operation the next edge: state IDLE, outputs at reset values. No partial result is emitted.
- Throughput: one result per 16 cycles minimum (15 + handshake), given `out_ready` tied high.

## Configuration
- `FPU_DIV_STATUS_EN` defined: the `flags` port exists and is registered with `quotient`.
  - invalid: NaN operand, 0/0, or inf/inf.
  - div_by_zero: finite nonzero / 0.
  - overflow: E >= 31 after rounding.
  - underflow: E <= 0.
  - inexact: guard | sticky, or overflow, or underflow.
- `FPU_DIV_STATUS_EN` undefined: the port and its logic are absent; `quotient` behaviour is identical.

## Test plan
- 16'h4200 / 16'h3E00 (3.0/1.5) -> 16'h4000 at exactly 15 cycles after accept; flags 5'b00000.
- 16'h3C00 / 16'h4200 (1.0/3.0) -> 16'h3555 (RNE); inexact=1.
- 16'hBC00 / 16'h0000 -> 16'hFC00, div_by_zero=1, latency 1; 16'h0000 / 16'h0000 -> 16'hFFFF, invalid=1.
- 16'h7BFF / 16'h3800 (65504/0.5) -> 16'h7C00, overflow=1; 16'h0400 / 16'h7800 -> 16'h0000, underflow=1.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` -> `quotient` stable, `in_ready`=0, a new `in_valid` is ignored; release -> IDLE next edge, then accept.
- Assert `RST` at DIV cycle 6 -> next edge `in_ready`=1, `out_valid`=0, `quotient`=16'h0000; a subsequent 3.0/1.5 still yields 16'h4000.
